mastermind_scorer: RTL
======================

# mastermind_scorer

Scoring datapath for the Mastermind game. It sits directly downstream of the game control FSM and holds the 4-peg secret code and the current 4-peg guess. It scores the guess one position per cycle, driven by the FSM's `compare`/`compare_i` sequence, and publishes black/white peg counts plus win status to the display logic.

## Interface
Parameters:
- `COLOR_W`, 3: bits per peg colour.
- `MAX_GUESSES`, 10: guess limit. Used only when `SCORER_GUESS_LIMIT_EN` is defined.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `color_in`  in  COLOR_W  peg colour from the switches.
- `load_code_1`..`load_code_4`  in  1 each  write `color_in` into code slot 0..3.
- `load_guess_1`..`load_guess_4`  in  1 each  write `color_in` into guess slot 0..3.
- `compare`  in  1  scoring step enable.
- `compare_i`  in  2  position scored this step.
- `reach_result_3`  in  1  final scoring step marker.
- `black`  out  3  exact-position matches of the last completed guess (0..4).
- `white`  out  3  colour-only matches of the last completed guess (0..4).
- `result_valid`  out  1  one-cycle pulse when `black`/`white` update.
- `win`  out  1  sticky; set when a completed guess scores `black==4`.
- `lose`  out  1  sticky; see Configuration.

## Operation
Registers:
- `code[0..3]`, `guess[0..3]`
- accumulators `acc_b`, `acc_w` (3 bits each)
- `used[3:0]`, code positions already consumed by a white match
- output registers `black`, `white`, `win`, `lose`, `result_valid`

Behaviour:
- **Load:** on an edge with `load_code_k` high, `code[k-1] <= color_in`; `load_guess_k` works the same way for `guess`. Multiple load strobes high at once write all selected slots.
- **Exact-match vector:** `ex[j] = (code[j]==guess[j])`, computed combinationally from the registered values.
- **Scoring step:** on an edge with `compare` high, let `i = compare_i`.
  - If `compare_i==0`, the step first clears `acc_b`, `acc_w` and `used`, then accumulates.
  - If `ex[i]`: `acc_b += 1`.
  - Otherwise, find the lowest `j != i` with `code[j]==guess[i]`, `!ex[j]` and `!used[j]`. If one exists: `acc_w += 1`, `used[j] <= 1`. If none: no change.
- **Final step:** on the step edge with `reach_result_3` high:
  - `black`/`white` load the final totals (this step's contribution included).
  - `result_valid` pulses on the following cycle.
  - `win` is set if final `black==4`.
- `black`/`white` hold the previous result throughout the next guess entry.
- Once `win` or `lose` is set, loads and compare steps are ignored and all outputs freeze until `reset`.
- Load and compare on the same edge: both take effect. Scoring uses pre-edge register values.
- Out-of-order `compare_i` is processed as given. No checking is done.

## Timing
- Reset values: `code`, `guess`, `acc_b`, `acc_w`, `used` = 0; `black=0`, `white=0`, `result_valid=0`, `win=0`, `lose=0`.
- Latency: 4 consecutive compare cycles (i=0..3). `black`/`white` are valid on the edge that ends the `i=3` cycle; `result_valid` is high for exactly the cycle after that edge.
- Gaps between compare cycles are allowed. The accumulators hold their values across gaps.
- `reset` asserted mid-scoring aborts the sequence. All registers return to reset values on that edge, and no `result_valid` is produced.
- Widths: the accumulators cannot exceed 4 (one increment per step), so there is no overflow handling.

## Configuration
- `SCORER_GUESS_LIMIT_EN` defined:
  - A 4-bit guess counter (reset 0) increments on each final step.
  - If the counter reaches `MAX_GUESSES` with final `black!=4`, `lose` is set on that same edge.
  - `win` takes priority over `lose` when both conditions hit on the same final step.
- `SCORER_GUESS_LIMIT_EN` undefined: no counter exists, `lose` is tied to 0, and guesses are unlimited.

## Test plan
- **Exact win:** code 1,2,3,4; guess 1,2,3,4; steps i=0..3 -> `black=4`, `white=0`, one-cycle `result_valid`, `win=1`. Further loads are ignored.
- **All whites:** code 1,1,2,2; guess 2,2,1,1 -> `black=0`, `white=4`, `win=0`.
- **Duplicate colours:** code 1,1,2,3; guess 1,2,1,1 -> `black=1`, `white=2`. Then code 1,2,3,4 with guess 1,1,1,1 -> `black=1`, `white=0`.
- **Hold:** after a result of 1/2, load a new guess without comparing -> `black`/`white` stay 1/2 and `result_valid` stays 0.
- **Reset mid-score:** `reset` asserted during the i=2 step -> all outputs 0, no `result_valid`. A fresh 4-step sequence afterwards scores correctly.
- **Guess limit:** with `SCORER_GUESS_LIMIT_EN` and `MAX_GUESSES=2`, two non-winning guesses -> `lose=1` on the second final step and the block freezes. Without the macro -> `lose` stays 0.

Source files
------------

// File: rtl/mastermind_scorer.sv
// -----------------------------------------------------------------------------
// mastermind_scorer
//
// Scoring datapath for Mastermind. Holds the 4-peg secret code and the
// current 4-peg guess. It scores the guess one position per compare step and
// publishes black/white peg counts and win/lose status.
//
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous, active-high reset
//   color_in            peg colour from the switches
//   load_code_1..4      write color_in into code slot 0..3
//   load_guess_1..4     write color_in into guess slot 0..3
//   compare             scoring step enable
//   compare_i           position scored this step
//   reach_result_3      marks the final scoring step
//   black / white       exact / colour-only matches of the last completed guess
//   result_valid        one-cycle pulse after black/white update
//   win                 sticky, set when a completed guess scores black==4
//   lose                sticky, set when the guess limit runs out
//
// Optional feature (macro SCORER_GUESS_LIMIT_EN):
//   defined   -> a 4-bit guess counter sets lose when MAX_GUESSES is reached
//                without a win.
//   undefined -> no counter, lose is tied to 0, guesses are unlimited.
// -----------------------------------------------------------------------------
module mastermind_scorer #(
  parameter int COLOR_W     = 3,
  parameter int MAX_GUESSES = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               load_code_1,
  input  logic               load_code_2,
  input  logic               load_code_3,
  input  logic               load_code_4,
  input  logic               load_guess_1,
  input  logic               load_guess_2,
  input  logic               load_guess_3,
  input  logic               load_guess_4,
  input  logic               compare,
  input  logic [1:0]         compare_i,
  input  logic               reach_result_3,
  output logic [2:0]         black,
  output logic [2:0]         white,
  output logic               result_valid,
  output logic               win,
  output logic               lose
);

  typedef logic [COLOR_W-1:0] color_t;

  // The guess counter is 4 bits wide, so the limit must fit in it.
  if (MAX_GUESSES < 1 || MAX_GUESSES > 15) begin : g_bad_max_guesses
    $error("MAX_GUESSES must be in 1..15");
  end

  color_t     code_q  [4];
  color_t     code_d  [4];
  color_t     guess_q [4];
  color_t     guess_d [4];
  logic [2:0] acc_b_q, acc_b_d;
  logic [2:0] acc_w_q, acc_w_d;
  logic [3:0] used_q, used_d;
  logic [2:0] black_q, black_d;
  logic [2:0] white_q, white_d;
  logic       result_valid_q, result_valid_d;
  logic       win_q, win_d;

  logic [3:0] ex;
  logic [3:0] load_code_v, load_guess_v;
  logic       frozen;
  logic       step;
  logic       final_step;
  logic [2:0] acc_b_base, acc_w_base;
  logic [3:0] used_base;
  logic       white_found;
  logic [1:0] white_j;

  assign load_code_v  = {load_code_4, load_code_3, load_code_2, load_code_1};
  assign load_guess_v = {load_guess_4, load_guess_3, load_guess_2, load_guess_1};

  // Once the game is decided nothing moves until reset.
  assign frozen     = win_q | lose;
  assign step       = compare & ~frozen;
  assign final_step = step & reach_result_3;

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      ex[j] = (code_q[j] == guess_q[j]);
    end
  end

  // Position 0 starts a fresh scoring pass, so it sees cleared accumulators.
  assign acc_b_base = (compare_i == 2'd0) ? 3'd0 : acc_b_q;
  assign acc_w_base = (compare_i == 2'd0) ? 3'd0 : acc_w_q;
  assign used_base  = (compare_i == 2'd0) ? 4'd0 : used_q;

  // Lowest code position that can still absorb a colour-only match for the
  // guess peg at compare_i. Exact-match positions are never borrowed.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    white_found = 1'b0;
    white_j     = 2'd0;
    for (int j = 0; j < 4; j++) begin
      if (!white_found && (j != int'(compare_i)) &&
          (code_q[j] == guess_q[compare_i]) && !ex[j] && !used_base[j]) begin
        white_found = 1'b1;
        white_j     = 2'(j);
      end
    end
  end

  always_comb begin
    // NOTE: combinational next-state logic uses blocking assignments; the
    // registers below take these values with non-blocking assignments.
    code_d         = code_q;
    guess_d        = guess_q;
    acc_b_d        = acc_b_q;
    acc_w_d        = acc_w_q;
    used_d         = used_q;
    black_d        = black_q;
    white_d        = white_q;
    result_valid_d = 1'b0;
    win_d          = win_q;

    if (!frozen) begin
      for (int k = 0; k < 4; k++) begin
        if (load_code_v[k])  code_d[k]  = color_in;
        if (load_guess_v[k]) guess_d[k] = color_in;
      end
    end

    if (step) begin
      acc_b_d = acc_b_base;
      acc_w_d = acc_w_base;
      used_d  = used_base;
      if (ex[compare_i]) begin
        acc_b_d = acc_b_base + 3'd1;
      end else if (white_found) begin
        acc_w_d          = acc_w_base + 3'd1;
        used_d[white_j]  = 1'b1;
      end
    end

    // Final totals include this step's contribution.
    if (final_step) begin
      black_d        = acc_b_d;
      white_d        = acc_w_d;
      result_valid_d = 1'b1;
      if (acc_b_d == 3'd4) win_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the code/guess arrays are reset explicitly because their
      // reset value of zero is architecturally visible.
      for (int k = 0; k < 4; k++) begin
        code_q[k]  <= '0;
        guess_q[k] <= '0;
      end
      acc_b_q        <= 3'd0;
      acc_w_q        <= 3'd0;
      used_q         <= 4'd0;
      black_q        <= 3'd0;
      white_q        <= 3'd0;
      result_valid_q <= 1'b0;
      win_q          <= 1'b0;
    end else begin
      code_q         <= code_d;
      guess_q        <= guess_d;
      acc_b_q        <= acc_b_d;
      acc_w_q        <= acc_w_d;
      used_q         <= used_d;
      black_q        <= black_d;
      white_q        <= white_d;
      result_valid_q <= result_valid_d;
      win_q          <= win_d;
    end
  end

`ifdef SCORER_GUESS_LIMIT_EN
  logic [3:0] guess_cnt_q, guess_cnt_d;
  logic       lose_q, lose_d;

  // win has priority: lose only fires on a non-winning final step.
  always_comb begin
    guess_cnt_d = guess_cnt_q;
    lose_d      = lose_q;
    if (final_step) begin
      guess_cnt_d = guess_cnt_q + 4'd1;
      if ((guess_cnt_d == 4'(MAX_GUESSES)) && (acc_b_d != 3'd4)) lose_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      guess_cnt_q <= 4'd0;
      lose_q      <= 1'b0;
    end else begin
      guess_cnt_q <= guess_cnt_d;
      lose_q      <= lose_d;
    end
  end

  assign lose = lose_q;
`else
  assign lose = 1'b0;
`endif

  assign black        = black_q;
  assign white        = white_q;
  assign result_valid = result_valid_q;
  assign win          = win_q;

endmodule
